// File: rtl/vga_scan_driver.sv
// Raster timing generator and registered pixel output stage for a VGA DAC.
// Scans DrawX/DrawY, samples the returned colour, and aligns sync/blank/colour to one pixel.
module vga_scan_driver #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start,
  output logic       vblank_tick
);

  localparam int unsigned CW       = 10;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    h_q, h_d;
  logic [CW-1:0]    v_q, v_d;
  logic             vclk_q, vclk_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [7:0]       b_q, b_d;
  logic             fs_q, fs_d;
  logic             vb_q, vb_d;

  logic pix_en;
  logic h_wrap;
  logic v_wrap;
  logic active;

  assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_wrap = (h_q == CW'(H_TOTAL - 1));
  assign v_wrap = (v_q == CW'(V_TOTAL - 1));
  assign active = (h_q < CW'(H_VISIBLE)) && (v_q < CW'(V_VISIBLE));

  // Next-state: divider always runs; counters and output stage advance on pix_en only.
  always_comb begin
    div_d     = pix_en ? '0 : div_q + DIV_W'(1);
    vclk_d    = (div_d >= DIV_W'(CLK_DIV / 2));
    h_d       = h_q;
    v_d       = v_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    fs_d      = 1'b0;
    vb_d      = 1'b0;
    if (pix_en) begin
      h_d = h_wrap ? '0 : h_q + CW'(1);
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + CW'(1);
      end
      // Output stage reflects the pre-increment position: one pixel behind DrawX/DrawY.
      blank_n_d = active;
      r_d       = active ? Red_in   : 8'h00;
      g_d       = active ? Green_in : 8'h00;
      b_d       = active ? Blue_in  : 8'h00;
      hs_d      = !((h_q >= CW'(HS_START)) && (h_q < CW'(HS_END)));
      vs_d      = !((v_q >= CW'(VS_START)) && (v_q < CW'(VS_END)));
      fs_d      = h_wrap && v_wrap;
      vb_d      = h_wrap && (v_q == CW'(V_VISIBLE - 1));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      vclk_q    <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      fs_q      <= 1'b0;
      vb_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      vclk_q    <= vclk_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      fs_q      <= fs_d;
      vb_q      <= vb_d;
    end
  end

  assign DrawX       = h_q;
  assign DrawY       = v_q;
  assign VGA_CLK     = vclk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign frame_start = fs_q;
  assign vblank_tick = vb_q;

endmodule
